// File: rtl/pio_in_edge_irq_pkg.sv
// rtl/pio_in_edge_irq_pkg.sv - shared constants and helpers for the PIO edge-capture input port
//
// Purpose: register addresses, edge-type encodings, parameter limits and the
// per-bit edge classifier used by pio_in_edge_irq.
// Ports: none (package).
package pio_pkg;

  // Word addresses on the 4-word slave window
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Parameter limits
  localparam int MAX_WIDTH    = 32;
  localparam int MAX_DEBOUNCE = 65535;

  // Debounce counter width, sized to count up to MAX_DEBOUNCE-1
  localparam int DEB_CNT_W = 16;

  // Classify one bit's transition from previous (p) to current (f) value
  function automatic logic edge_bit(input logic f, input logic p, input int sel);
    logic hit;
    case (sel)
      EDGE_FALLING: hit = ~f & p;
      EDGE_ANY:     hit = f ^ p;
      default:      hit = f & ~p;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// rtl/pio_in_edge_irq_if.sv - Avalon-MM slave bus bundle for the PIO edge-capture port
//
// Purpose: groups the word-addressed register bus of pio_in_edge_irq.
// Signals:
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (driven by the slave)
interface pio_avmm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_irq_debounce.sv
// rtl/pio_in_edge_irq_debounce.sv - single-bit debounce filter
//
// Purpose: the filtered output follows the raw synchronised input only after
// DEBOUNCE consecutive samples that differ from the current filtered value.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   raw_i    in   synchronised input bit
//   filt_o   out  filtered bit
module pio_debounce
  import pio_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic filt_o
);

  logic                 filt_q, filt_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (raw_i == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_CNT_W'(DEBOUNCE - 1)) begin
      // This is the DEBOUNCE-th differing sample in a row
      filt_d = raw_i;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/pio_in_edge_irq.sv
// rtl/pio_in_edge_irq.sv - synchronised, debounced input port with edge capture and maskable irq
//
// Purpose: samples a WIDTH-bit asynchronous input bus, optionally debounces it,
// latches per-bit edges into EDGE_CAPTURE and raises a level irq for unmasked
// captured bits. Register map: 0 DATA (RO), 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of pio_avmm_if (address/chipselect/write_n/writedata/readdata)
//   in_port  in   WIDTH asynchronous input pins
//   irq      out  level interrupt, active-high
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0,
  parameter int BIT_CLEAR   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_avmm_if.slave        bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_stb;

  // Synchroniser chain; stage 0 is the metastability-exposed flop
  always_comb begin
    sync_d[0] = in_port;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      assign filt = raw;
    end else begin : g_debounce
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
          .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
          .clk     (clk),
          .reset_n (reset_n),
          .raw_i   (raw[i]),
          .filt_o  (filt[i])
        );
      end
    end
  endgenerate

  assign wr_stb = bus.chipselect & ~bus.write_n;

  always_comb begin
    prev_d = filt;

    for (int i = 0; i < WIDTH; i++) begin
      edge_hit[i] = edge_bit(filt[i], prev_q[i], EDGE_TYPE);
    end

    clr = '0;
    if (wr_stb && bus.address == ADDR_CAPTURE) begin
      clr = (BIT_CLEAR != 0) ? bus.writedata[WIDTH-1:0] : '1;
    end
    // Edge is ORed in after the clear so a coincident event is never lost
    cap_d = (cap_q & ~clr) | edge_hit;

    mask_d = mask_q;
    if (wr_stb && bus.address == ADDR_MASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end

    // Read mux runs every cycle regardless of chipselect
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:    readdata_d = 32'(filt);
      ADDR_MASK:    readdata_d = 32'(mask_q);
      ADDR_CAPTURE: readdata_d = 32'(cap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      cap_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

  // Driven only from flops, so in_port cannot glitch irq
  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb/tb_pio_in_edge_irq.sv - self-checking bench for pio_in_edge_irq
module tb_pio_in_edge_irq;

  localparam int N = 3;

  // Instance configurations: 0 defaults, 1 any-edge/debounced/clear-all, 2 falling/wide
  int pw[N] = '{8, 4, 32};
  int pe[N] = '{0, 2, 1};
  int ps[N] = '{2, 3, 4};
  int pd[N] = '{0, 4, 1};
  int pb[N] = '{1, 0, 1};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]  ad[N];
  logic        cs[N];
  logic        wn[N];
  logic [31:0] wd[N];
  logic [31:0] inp[N];
  logic [31:0] rdo[N];
  logic        irqo[N];

  pio_avmm_if bus0 ();
  pio_avmm_if bus1 ();
  pio_avmm_if bus2 ();

  assign bus0.address = ad[0]; assign bus0.chipselect = cs[0];
  assign bus0.write_n = wn[0]; assign bus0.writedata  = wd[0];
  assign bus1.address = ad[1]; assign bus1.chipselect = cs[1];
  assign bus1.write_n = wn[1]; assign bus1.writedata  = wd[1];
  assign bus2.address = ad[2]; assign bus2.chipselect = cs[2];
  assign bus2.write_n = wn[2]; assign bus2.writedata  = wd[2];
  assign rdo[0] = bus0.readdata;
  assign rdo[1] = bus1.readdata;
  assign rdo[2] = bus2.readdata;

  pio_in_edge_irq #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE(0), .BIT_CLEAR(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(inp[0][7:0]), .irq(irqo[0]));
  pio_in_edge_irq #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(3), .DEBOUNCE(4), .BIT_CLEAR(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(inp[1][3:0]), .irq(irqo[1]));
  pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(1), .SYNC_STAGES(4), .DEBOUNCE(1), .BIT_CLEAR(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(inp[2]), .irq(irqo[2]));

  int total = 0;
  int bad   = 0;

  // Reference model: pin history per instance plus architectural register values
  logic [31:0] hist[N][16];
  logic [31:0] m_f[N], m_p[N], m_cap[N], m_mask[N], m_rd[N];

  function automatic logic [31:0] wmask(input int i);
    return (pw[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << pw[i]) - 32'd1);
  endfunction

  function automatic logic m_irq(input int i);
    return |(m_cap[i] & m_mask[i]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_f[i] = '0; m_p[i] = '0; m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
      for (int j = 0; j < 16; j++) hist[i][j] = '0;
    end
  endtask

  // One rising clock edge worth of behaviour, using the inputs held across it
  task automatic model_edge(input int i);
    logic [31:0] m, of, op, eg, clr;
    logic wr, flip;
    m  = wmask(i);
    of = m_f[i];
    op = m_p[i];
    case (pe[i])
      0:       eg = of & ~op;
      1:       eg = ~of & op;
      default: eg = of ^ op;
    endcase
    eg = eg & m;
    wr = cs[i] && !wn[i];
    clr = '0;
    if (wr && ad[i] == 2'd3) clr = ((pb[i] == 1) ? wd[i] : 32'hFFFF_FFFF) & m;
    case (ad[i])
      2'd0:    m_rd[i] = of;
      2'd2:    m_rd[i] = m_mask[i];
      2'd3:    m_rd[i] = m_cap[i];
      default: m_rd[i] = '0;
    endcase
    m_cap[i] = (m_cap[i] & ~clr) | eg;
    if (wr && ad[i] == 2'd2) m_mask[i] = wd[i] & m;
    m_p[i] = of;
    for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
    hist[i][0] = inp[i] & m;
    if (pd[i] == 0) begin
      m_f[i] = hist[i][ps[i]-1];
    end else begin
      // Filtered bit flips once the last DEBOUNCE synchronised samples all disagree with it
      for (int b = 0; b < pw[i]; b++) begin
        flip = 1'b1;
        for (int k = 0; k < pd[i]; k++) begin
          if (hist[i][ps[i]+k][b] == m_f[i][b]) flip = 1'b0;
        end
        if (flip) m_f[i][b] = ~m_f[i][b];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("readdata%0d", i), rdo[i], m_rd[i]);
      check($sformatf("irq%0d", i), 32'(irqo[i]), 32'(m_irq(i)));
    end
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic bus_wr(input int i, input logic [1:0] a, input logic [31:0] d);
    ad[i] = a; wd[i] = d; cs[i] = 1'b1; wn[i] = 1'b0;
    cyc();
    cs[i] = 1'b0; wn[i] = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      ad[i] = 2'd0; cs[i] = 1'b0; wn[i] = 1'b1; wd[i] = '0; inp[i] = '0;
    end
    model_reset();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_rd%0d", i), rdo[i], 32'h0);
      check($sformatf("reset_irq%0d", i), 32'(irqo[i]), 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Rising edge on bit 0 lands in capture two edges after sampling
    ad[0] = 2'd3;
    cycn(9);
    inp[0] = 32'h01;
    cyc();
    check("cap_lat_e10", rdo[0], 32'h0);
    cycn(2);
    check("cap_lat_e12", rdo[0], 32'h0);
    cyc();
    check("cap_read_e13", rdo[0], 32'h1);
    check("cap_irq_masked", 32'(irqo[0]), 32'h0);

    // Mask bits 1:0, pulse bit 1, then clear it
    bus_wr(0, 2'd3, 32'h1);
    bus_wr(0, 2'd2, 32'h3);
    inp[0] = 32'h03;
    cyc();
    inp[0] = 32'h01;
    cyc();
    check("irq_k1", 32'(irqo[0]), 32'h0);
    cyc();
    check("irq_k2", 32'(irqo[0]), 32'h1);
    bus_wr(0, 2'd3, 32'h2);
    check("irq_after_clr", 32'(irqo[0]), 32'h0);
    cyc();
    check("cap_after_clr", rdo[0], 32'h0);

    // Clear and new edge on bit 0 in the same cycle
    inp[0] = 32'h00;
    cycn(3);
    inp[0] = 32'h01;
    cycn(2);
    bus_wr(0, 2'd3, 32'h1);
    cyc();
    check("edge_beats_clr", rdo[0] & 32'h1, 32'h1);
    check("edge_beats_clr_irq", 32'(irqo[0]), 32'h1);

    // Debounce: 3-cycle glitch is filtered
    ad[1] = 2'd0;
    inp[1] = 32'h1;
    cycn(3);
    inp[1] = 32'h0;
    cycn(10);
    check("glitch_data", rdo[1], 32'h0);
    ad[1] = 2'd3;
    cyc();
    check("glitch_cap", rdo[1], 32'h0);

    // Stable high: DATA after SYNC_STAGES-1+DEBOUNCE edges, visible one read later
    ad[1] = 2'd0;
    inp[1] = 32'h1;
    cycn(7);
    check("deb_data_early", rdo[1], 32'h0);
    cyc();
    check("deb_data", rdo[1], 32'h1);

    // Any-edge on bit 3, clear-all on any write
    bus_wr(1, 2'd3, 32'h0);
    cyc();
    check("clrall_cap", rdo[1], 32'h0);
    inp[1] = 32'h9;
    cycn(10);
    check("any_rise", rdo[1], 32'h8);
    bus_wr(1, 2'd3, 32'h0);
    cyc();
    check("any_clr", rdo[1], 32'h0);
    inp[1] = 32'h1;
    cycn(10);
    check("any_fall", rdo[1], 32'h8);

    // Randomised traffic on all instances against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) inp[i] = $urandom & wmask(i);
        ad[i] = 2'($urandom_range(3));
        cs[i] = 1'($urandom_range(1));
        wn[i] = ($urandom_range(3) != 0);
        wd[i] = $urandom;
      end
      cyc();
    end
    for (int i = 0; i < N; i++) begin
      cs[i] = 1'b0; wn[i] = 1'b1;
    end

    // Asynchronous reset with a pending, unmasked capture
    bus_wr(0, 2'd2, 32'hFF);
    ad[0] = 2'd3;
    inp[0] = 32'h00;
    cycn(3);
    inp[0] = 32'hFF;
    cycn(4);
    check("pre_reset_irq", 32'(irqo[0]), 32'h1);
    check("pre_reset_cap", rdo[0], 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("async_rd%0d", i), rdo[i], 32'h0);
      check($sformatf("async_irq%0d", i), 32'(irqo[i]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Input already high at reset release yields a rising edge
    cycn(3);
    check("post_reset_e3", rdo[0], 32'h0);
    cyc();
    check("post_reset_e4", rdo[0], 32'hFF);
    cycn(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_irq.md
# pio_in_edge_irq

Parametrised Avalon-MM input port for board status lines (USB, keys, DIP switches). It synchronises and optionally debounces a WIDTH-bit input bus. Edges are captured per bit with a selectable edge type, and a maskable level interrupt is raised to the Nios II interrupt controller. It sits on the system Avalon bus as a 4-word slave, one instance per input group.

## Interface
- WIDTH, 8: number of input bits, 1..32.
- EDGE_TYPE, 0: edge captured. 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE, 0: stable cycles required before the filtered value changes. 0 = filter bypassed; maximum 65535.
- BIT_CLEAR, 1: 1 = write-1-to-clear per bit at address 3; 0 = any write to address 3 clears all bits.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous input pins.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 = DATA (RO, filtered value; writes ignored).
  - 1 = reserved (reads 0, writes ignored).
  - 2 = IRQ_MASK (RW, WIDTH bits).
  - 3 = EDGE_CAPTURE (read; write clears).
- Bits [31:WIDTH] always read 0.
- Write strobe: chipselect & ~write_n.
- Synchroniser: each bit passes through a SYNC_STAGES-flop chain. Its last stage is the raw synchronised value r.
- Debounce, per bit (DEBOUNCE > 0):
  - An up-counter runs while r != f and resets to 0 when r == f.
  - f takes r and the counter clears on the cycle the counter reaches DEBOUNCE-1 with r still != f. The new value therefore appears after DEBOUNCE consecutive differing samples.
  - A glitch shorter than DEBOUNCE cycles never reaches f.
- DEBOUNCE = 0: f = r.
- Previous-value register p <= f every cycle.
- Edge detect, combinational, registered into the capture:
  - rising = f & ~p
  - falling = ~f & p
  - any = f ^ p
- EDGE_CAPTURE[i] is set by an edge on bit i and held until cleared by software.
- Clearing:
  - BIT_CLEAR = 1: a write to address 3 clears the bits where writedata[i] = 1.
  - BIT_CLEAR = 0: any write to address 3 clears all bits.
- Simultaneous edge and clear on the same bit in the same cycle: the edge wins and the bit stays/becomes 1, so no event is lost.
- IRQ_MASK written from writedata[WIDTH-1:0] on a write to address 2.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers; no glitch path from in_port.
- readdata is loaded every clock from the current address, independent of chipselect.

## Timing
- Reset values are 0 for all of the following: readdata, irq, IRQ_MASK, EDGE_CAPTURE, synchroniser flops, debounce counters, f, p.
- An input already high at reset release produces a rising (or any) edge after the sync latency. This is required behaviour.
- Read latency: 1 clock. readdata is valid on the edge after address is presented; no waitrequest.
- Writes take effect on the clock edge where the strobe is sampled. They are visible to a read issued on the next cycle.
- Capture latency with DEBOUNCE = 0: in_port change sampled at edge k → EDGE_CAPTURE and irq set after edge k+SYNC_STAGES. With the defaults, k+2.
- DEBOUNCE > 0 adds DEBOUNCE cycles to both DATA and capture latency.
- A mask change affects irq immediately after the write edge. Unmasking a pending capture asserts irq at that edge.
- Reset mid-operation:
  - Asynchronous reset clears all state immediately.
  - A pending capture is lost.
  - readdata and irq drop to 0 without waiting for clk.

## Structure
- Package pio_pkg:
  - address constants ADDR_DATA/ADDR_MASK/ADDR_CAPTURE.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
  - max WIDTH/DEBOUNCE constants.
- Sub-module pio_debounce: one bit, parameter DEBOUNCE. Instantiated WIDTH times in a generate loop and bypassed by generate when DEBOUNCE = 0.
- Top level holds the synchroniser, edge detect, registers and read mux.

## Test plan
- Reset with in_port = 0, defaults. Assert 8'h01 at edge 10 → EDGE_CAPTURE = 0x01 after edge 12. Read address 3 → readdata = 0x00000001 one clock later. irq stays 0 (mask 0).
- Write IRQ_MASK = 0x03, then pulse bit 1. irq rises 2 clocks after sampling. Write 0x02 to address 3 → capture 0x00 and irq 0 next cycle.
- EDGE_TYPE = 2, WIDTH = 4. Toggle bit 3 high then low, reading and clearing between toggles. The capture is set on both transitions.
- DEBOUNCE = 4. A 3-cycle glitch on bit 0 → DATA and EDGE_CAPTURE unchanged. A 4-cycle stable high → DATA = 1 four cycles later than the DEBOUNCE = 0 case.
- Clear write to address 3 on the same cycle a new edge lands on bit 0 → bit 0 reads 1 afterwards.
- BIT_CLEAR = 0, capture = 0xFF. Write 0 to address 3 → capture 0x00. Assert reset_n low mid-frame → readdata and irq 0 asynchronously.
